rr_encoder: RTL and testbench



---
 rtl/rr_encoder_pkg.sv | 10 +
 rtl/rr_encoder_if.sv | 18 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_encoder.sv | 95 +++++++++
 tb/tb_rr_encoder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_encoder_pkg.sv
// Shared types for the round-robin encoder: FSM state encoding.
// Optional feature macro: RR_ENCODER_FIXED_PRIORITY_EN (see rr_encoder.sv).
package rr_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rr_state_e;

endpackage

// File: rtl/rr_encoder_if.sv
// Request/grant bus of the round-robin encoder; master = encoder, slave = requesters + consumer.
interface rr_encoder_if #(
    parameter int INPUT_WIDTH = 3
);
    localparam int SELECTOR_WIDTH = $clog2(INPUT_WIDTH);

    logic [INPUT_WIDTH-1:0]    req;
    logic                      valid;
    logic                      ready;
    logic [SELECTOR_WIDTH-1:0] index;
    logic [INPUT_WIDTH-1:0]    grant;

    // valid/ready: a transfer happens on a rising clk edge where valid && ready;
    // once valid rises, index/grant are held until that edge; ready with valid=0 is ignored.
    modport master (input req, input ready, output valid, output index, output grant);
    modport slave  (output req, output ready, input valid, input index, input grant);

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-scan: first set req bit at or above pointer, wrapping to bit 0.
module rr_pick #(
    parameter  int INPUT_WIDTH    = 3,
    localparam int SELECTOR_WIDTH = $clog2(INPUT_WIDTH)
) (
    input  logic [INPUT_WIDTH-1:0]    req,
    input  logic [SELECTOR_WIDTH-1:0] pointer,
    output logic                      any,
    output logic [SELECTOR_WIDTH-1:0] pick
);

    int                        idx;
    logic [SELECTOR_WIDTH-1:0] cand;

    always_comb begin
        any  = 1'b0;
        pick = '0;
        idx  = 0;
        cand = '0;
        for (int k = 0; k < INPUT_WIDTH; k++) begin
            // Explicit wrap so non-power-of-2 widths never produce an out-of-range candidate.
            idx = int'(pointer) + k;
            if (idx >= INPUT_WIDTH) idx = idx - INPUT_WIDTH;
            cand = SELECTOR_WIDTH'(idx);
            if (!any && req[cand]) begin
                any  = 1'b1;
                pick = cand;
            end
        end
    end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin encoder: registers one granted index/one-hot grant and holds it until handshake.
// Define RR_ENCODER_FIXED_PRIORITY_EN to drop the pointer and always pick the lowest set req bit.
module rr_encoder
    import rr_encoder_pkg::*;
#(
    parameter int INPUT_WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    rr_encoder_if.master bus,
    output rr_state_e    dbg_state
);

    localparam int SELECTOR_WIDTH = $clog2(INPUT_WIDTH);

    rr_state_e                 state_q, state_d;
    logic                      valid_q, valid_d;
    logic [SELECTOR_WIDTH-1:0] index_q, index_d;
    logic [INPUT_WIDTH-1:0]    grant_q, grant_d;
    logic [SELECTOR_WIDTH-1:0] pointer;
    logic [SELECTOR_WIDTH-1:0] pick;
    logic                      any;
    logic                      handshake;

    rr_pick #(.INPUT_WIDTH(INPUT_WIDTH)) u_pick (
        .req     (bus.req),
        .pointer (pointer),
        .any     (any),
        .pick    (pick)
    );

    assign handshake = (state_q == HOLD) && bus.ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        index_d = index_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    index_d = pick;
                    grant_d = INPUT_WIDTH'(1) << pick;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // index keeps its value; only valid/grant drop.
                if (bus.ready) begin
                    valid_d = 1'b0;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            index_q <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            index_q <= index_d;
            grant_q <= grant_d;
        end
    end

`ifdef RR_ENCODER_FIXED_PRIORITY_EN
    assign pointer = '0;
`else
    logic [SELECTOR_WIDTH-1:0] pointer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pointer_q <= '0;
        end else if (handshake) begin
            pointer_q <= (index_q == SELECTOR_WIDTH'(INPUT_WIDTH - 1)) ? '0 : index_q + 1'b1;
        end
    end

    assign pointer = pointer_q;
`endif

    assign bus.valid = valid_q;
    assign bus.index = index_q;
    assign bus.grant = grant_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rr_encoder.sv
// Self-checking bench for rr_encoder: 3-wide and 5-wide instances, scoreboard of expected grants.
module tb_rr_encoder;
  import rr_encoder_pkg::*;

  logic clk;
  logic rst;
  rr_state_e st3, st5;

  rr_encoder_if #(.INPUT_WIDTH(3)) b3 ();
  rr_encoder_if #(.INPUT_WIDTH(5)) b5 ();

  rr_encoder #(.INPUT_WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3), .dbg_state(st3));
  rr_encoder #(.INPUT_WIDTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(b5), .dbg_state(st5));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q3[$];
  logic [7:0] exp_q5[$];

  logic       rst_v;
  logic [2:0] req3;
  logic       rdy3;
  logic [4:0] req5;
  logic       rdy5;
  int         mptr3;
  int         mptr5;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model of the arbitration choice
  function automatic int model_pick(input int req, input int ptr, input int w);
    int start;
`ifdef RR_ENCODER_FIXED_PRIORITY_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < w; k++) begin
      int i;
      i = (start + k) % w;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic push3(input int req);
    int e;
    e = model_pick(req, mptr3, 3);
    exp_q3.push_back(8'(e));
    mptr3 = (e + 1) % 3;
  endtask

  task automatic push5(input int req);
    int e;
    e = model_pick(req, mptr5, 5);
    exp_q5.push_back(8'(e));
    mptr5 = (e + 1) % 5;
  endtask

  // driver + monitor: drive at negedge, then pop for any handshake due on the next posedge
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    rst      = rst_v;
    b3.req   = req3;
    b3.ready = rdy3;
    b5.req   = req5;
    b5.ready = rdy5;
    if (b3.valid && b3.ready) begin
      if (exp_q3.size() == 0) check("sb3_unexpected_grant", 1, 0);
      else begin
        e = exp_q3.pop_front();
        check("idx3", int'(b3.index), int'(e));
        check("grant3", int'(b3.grant), 1 << e);
      end
    end
    if (b5.valid && b5.ready) begin
      if (exp_q5.size() == 0) check("sb5_unexpected_grant", 1, 0);
      else begin
        e = exp_q5.pop_front();
        check("idx5", int'(b5.index), int'(e));
        check("grant5", int'(b5.grant), 1 << e);
      end
    end
  endtask

  // n grants with constant req and ready=1 on one instance; valid must toggle 0,1,0,1...
  task automatic run_phase(input int sel, input int req, input int n);
    for (int g = 0; g < n; g++) begin
      if (sel == 0) push3(req);
      else push5(req);
    end
    for (int j = 0; j < 2 * n; j++) begin
      req3 = (sel == 0) ? 3'(req) : 3'b0;
      rdy3 = (sel == 0);
      req5 = (sel == 1) ? 5'(req) : 5'b0;
      rdy5 = (sel == 1);
      tick();
      if (sel == 0) begin
        check("valid3", int'(b3.valid), j % 2);
        check("state3", int'(st3), (j % 2 == 1) ? int'(HOLD) : int'(IDLE));
      end else begin
        check("valid5", int'(b5.valid), j % 2);
        check("state5", int'(st5), (j % 2 == 1) ? int'(HOLD) : int'(IDLE));
      end
    end
    check("drain3", exp_q3.size(), 0);
    check("drain5", exp_q5.size(), 0);
  endtask

  initial begin
    int hold_idx;
    int r;
    rst_v = 1'b1; rst = 1'b1;
    req3 = 3'b111; rdy3 = 1'b0; req5 = 5'b11111; rdy5 = 1'b0;
    b3.req = req3; b3.ready = rdy3; b5.req = req5; b5.ready = rdy5;
    mptr3 = 0; mptr5 = 0;

    // reset with requests held
    repeat (3) tick();
    check("rst_valid3", int'(b3.valid), 0);
    check("rst_grant3", int'(b3.grant), 0);
    check("rst_index3", int'(b3.index), 0);
    check("rst_state3", int'(st3), int'(IDLE));
    check("rst_valid5", int'(b5.valid), 0);
    check("rst_grant5", int'(b5.grant), 0);

    // release: first grant one edge later, then 0,1,2,0
    rst_v = 1'b0;
    run_phase(0, 3'b111, 4);

    // requester 1 idle: only 0 and 2 alternate
    run_phase(0, 3'b101, 4);

    // stall with ready=0 while req changes; grant must stay frozen
    push3(3'b111);
    hold_idx = int'(exp_q3[0]);
    push3(3'b100);
    req3 = 3'b111; rdy3 = 1'b0; req5 = '0; rdy5 = 1'b0;
    tick();
    check("hold_pre_valid", int'(b3.valid), 0);
    req3 = 3'b100;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("hold_valid", int'(b3.valid), 1);
      check("hold_index", int'(b3.index), hold_idx);
      check("hold_grant", int'(b3.grant), 1 << hold_idx);
    end
    rdy3 = 1'b1;
    tick();
    tick();
    check("hold_bubble", int'(b3.valid), 0);
    check("hold_bubble_grant", int'(b3.grant), 0);
    check("hold_index_kept", int'(b3.index), hold_idx);
    tick();
    check("hold_next_valid", int'(b3.valid), 1);
    check("hold_drain", exp_q3.size(), 0);
    req3 = '0;
    tick();

    // width 5: wrap 4 -> 0
    run_phase(1, 5'b10001, 3);
    run_phase(1, 5'b10000, 1);

    // async reset while holding a grant
    req3 = 3'b100; rdy3 = 1'b0; req5 = '0; rdy5 = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", int'(b3.valid), 1);
    check("pre_rst_index", int'(b3.index), model_pick(3'b100, mptr3, 3));
    #2;
    rst_v = 1'b1; rst = 1'b1;
    #1;
    check("async_rst_valid", int'(b3.valid), 0);
    check("async_rst_grant", int'(b3.grant), 0);
    check("async_rst_index", int'(b3.index), 0);
    check("async_rst_state", int'(st3), int'(IDLE));
    req3 = 3'b111;
    tick();
    check("in_rst_valid", int'(b3.valid), 0);
    mptr3 = 0; mptr5 = 0;
    rst_v = 1'b0;
    run_phase(0, 3'b111, 2);

    // random request patterns
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(1, 7);
      run_phase(0, r, 1);
      r = $urandom_range(1, 31);
      run_phase(1, r, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
